// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one instruction-memory read at a time from pc_current,
// hands the result to decode, and computes the next PC (sequential, hold or redirect).
module fetch_unit #(
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = 32'h00003000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_current,
  output logic [ADDR_W-1:0] pc_next,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [DATA_W-1:0] imem_resp_data,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              if_ready
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and the payload is stable while valid waits for ready.
  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                squash_q, squash_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic                if_valid_d;
  logic [DATA_W-1:0]   if_instr_d;
  logic [ADDR_W-1:0]   if_pc_d;
  logic                req_valid;
  logic [ADDR_W-1:0]   pc_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ISSUE;
      squash_q   <= 1'b0;
      fetch_pc_q <= RESET_ADDR;
      if_valid   <= 1'b0;
      if_instr   <= '0;
      if_pc      <= '0;
    end else begin
      state_q    <= state_d;
      squash_q   <= squash_d;
      fetch_pc_q <= fetch_pc_d;
      if_valid   <= if_valid_d;
      if_instr   <= if_instr_d;
      if_pc      <= if_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    squash_d   = squash_q;
    fetch_pc_d = fetch_pc_q;
    if_valid_d = if_valid;
    if_instr_d = if_instr;
    if_pc_d    = if_pc;
    req_valid  = 1'b0;
    pc_sel     = pc_current;
    case (state_q)
      ISSUE: begin
        req_valid = !redirect_valid;
        if (redirect_valid) begin
          pc_sel = redirect_addr;
        end else if (imem_req_ready) begin
          fetch_pc_d = pc_current;
          pc_sel     = pc_current + ADDR_W'(4);
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) pc_sel = redirect_addr;
        if (imem_resp_valid) begin
          // A redirect seen now or earlier in this wait makes the data stale.
          if (squash_q || redirect_valid) begin
            squash_d = 1'b0;
            state_d  = ISSUE;
          end else begin
            if_instr_d = imem_resp_data;
            if_pc_d    = fetch_pc_q;
            if_valid_d = 1'b1;
            state_d    = HOLD;
          end
        end else if (redirect_valid) begin
          squash_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_sel     = redirect_addr;
          if_valid_d = 1'b0;
          state_d    = ISSUE;
        end else if (if_ready) begin
          if_valid_d = 1'b0;
          state_d    = ISSUE;
        end
      end
      default: state_d = ISSUE;
    endcase
  end

  assign imem_req_valid = req_valid && !reset;
  assign imem_req_addr  = pc_current;
  assign pc_next        = (reset ? RESET_ADDR : pc_sel) & ~ADDR_W'(3);

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Consumer side of the PC register. Takes the current PC and issues one instruction-memory read at a time over a valid/ready request channel, then accepts the response. It hands the fetched instruction to decode with a valid/ready handshake. It computes the next PC that is fed back to the PC register: sequential +4, hold on stall, or branch/jump redirect. Sits between the PC register, instruction memory and the IF/ID boundary.

Parameters:
RESET_ADDR, 32'h00003000, PC value driven on pc_next while reset is asserted; also the reset value of the internal fetch PC.
ADDR_W, 32, address width.
DATA_W, 32, instruction width.

Ports:
clk  in  1  system clock; all state updates on its rising edge.
reset  in  1  asynchronous, active-high reset.
pc_current  in  ADDR_W  current PC from the PC register.
pc_next  out  ADDR_W  next PC to the PC register's next-address input (combinational).
redirect_valid  in  1  branch/jump taken this cycle.
redirect_addr  in  ADDR_W  branch/jump target.
imem_req_valid  out  1  instruction read request valid.
imem_req_addr  out  ADDR_W  read address; always equals pc_current.
imem_req_ready  in  1  memory accepts the request.
imem_resp_valid  in  1  read data valid (single-cycle pulse).
imem_resp_data  in  DATA_W  read data.
if_valid  out  1  fetched instruction valid to decode (registered).
if_instr  out  DATA_W  fetched instruction (registered).
if_pc  out  ADDR_W  PC of if_instr (registered).
if_ready  in  1  decode accepts the instruction.

Behaviour:
- FSM states: ISSUE, WAIT, HOLD. At most one outstanding memory request.
- Reset asserted, asynchronously:
  - state=ISSUE, squash=0, fetch_pc=RESET_ADDR.
  - if_valid=0, if_instr=0, if_pc=0.
  - While reset is high, imem_req_valid=0 and pc_next=RESET_ADDR.
- ISSUE:
  - imem_req_valid = !redirect_valid.
  - If redirect_valid: pc_next=redirect_addr; stay in ISSUE.
  - Else if imem_req_ready: fetch_pc<=pc_current; pc_next=pc_current+4; go to WAIT.
  - Else: pc_next=pc_current.
- WAIT:
  - imem_req_valid=0.
  - If imem_resp_valid and (squash or redirect_valid): discard the data, clear squash, go to ISSUE.
  - Else if imem_resp_valid: if_instr<=data, if_pc<=fetch_pc, if_valid<=1, go to HOLD.
  - If redirect_valid without a response: set squash, stay in WAIT.
  - pc_next = redirect_valid ? redirect_addr : pc_current.
- HOLD:
  - if_valid held at 1; if_instr and if_pc stable until accepted.
  - redirect_valid has priority over if_ready: if_valid<=0, pc_next=redirect_addr, go to ISSUE.
  - Else if if_ready: if_valid<=0, go to ISSUE.
  - Else: stall, pc_next=pc_current.
- Redirect and squash rules:
  - A redirect_valid pulse seen in any state is never lost.
  - pc_next[1:0] is always forced to 2'b00.
- Arithmetic: +4 is modulo 2^ADDR_W. 32'hFFFFFFFC wraps to 32'h00000000.
- imem_resp_valid in ISSUE or HOLD is ignored. This covers a stale response after a mid-operation reset.
- Throughput: minimum 3 cycles per instruction (ISSUE→WAIT→HOLD). Response latency is unbounded.

Test Plan:
- Reset release, pc_current=32'h3000, imem_req_ready=1, 1-cycle response 32'h2008000A, if_ready=1 -> pc_next=32'h3004 in the handshake cycle; if_valid=1 with if_instr=32'h2008000A and if_pc=32'h3000 two cycles later; next request address 32'h3004.
- if_ready held 0 for 5 cycles in HOLD -> if_valid, if_instr and if_pc stable; pc_next=pc_current; no request issued; proceeds on the cycle after if_ready=1.
- redirect_valid=1 with redirect_addr=32'h3100 in WAIT, response arrives 3 cycles later -> response discarded, if_valid stays 0, next request address 32'h3100.
- redirect_valid=1 in HOLD together with if_ready=1 -> instruction dropped (if_valid=0 next cycle); pc_next=32'h3100 in that cycle.
- pc_current=32'hFFFFFFFC, request accepted -> pc_next=32'h00000000; redirect_addr=32'h3103 -> pc_next=32'h3100.
- reset asserted mid-WAIT, then a late imem_resp_valid pulse after release -> all outputs return to reset values immediately; the late response is ignored; the first request is to pc_current.
